// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Holds the controller FSM encoding, the blank and dash segment patterns and the
// hex-nibble to active-low glyph lookup (seg[0]=a .. seg[6]=g, 0 = segment lit).
package sevenseg_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StConv   = 2'd1,
    StCommit = 2'd2
  } scan_state_e;

  localparam logic [6:0] SegBlank = 7'b111_1111;
  // Only segment g lit.
  localparam logic [6:0] SegDash  = 7'b011_1111;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b100_0000;
      4'h1:    g = 7'b111_1001;
      4'h2:    g = 7'b010_0100;
      4'h3:    g = 7'b011_0000;
      4'h4:    g = 7'b001_1001;
      4'h5:    g = 7'b001_0010;
      4'h6:    g = 7'b000_0010;
      4'h7:    g = 7'b111_1000;
      4'h8:    g = 7'b000_0000;
      4'h9:    g = 7'b001_0000;
      4'hA:    g = 7'b000_1000;
      4'hB:    g = 7'b000_0011;
      4'hC:    g = 7'b100_0110;
      4'hD:    g = 7'b010_0001;
      4'hE:    g = 7'b000_0110;
      4'hF:    g = 7'b000_1110;
      default: g = SegBlank;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter, one shift per clock.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   start_i        load bin_i and begin a DATA_W-cycle conversion
//   bin_i          binary value to convert
//   done_o         high during the cycle that performs the final shift
//   bcd_o          NUM_DIGITS BCD nibbles, digit 0 in bits [3:0]
//   ovf_o          value needs more than NUM_DIGITS decimal digits
module bin2bcd_seq #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DATA_W     = 13
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       bin_i,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    ovf_o
);

  localparam int unsigned BcdW = 4 * NUM_DIGITS;
  localparam int unsigned CntW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BcdW-1:0]   bcd_q, bcd_d, bcd_adj;
  logic              ovf_q, ovf_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Add-3 correction on every nibble that would exceed 9 after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      shift_d = bin_i;
      bcd_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = CntW'(DATA_W);
    end else if (cnt_q != '0) begin
      // A bit carried out of the top digit means the running prefix, and so the
      // final value, is at least 10^NUM_DIGITS; keep it sticky.
      bcd_d   = {bcd_adj[BcdW-2:0], shift_q[DATA_W-1]};
      ovf_d   = ovf_q | bcd_adj[BcdW-1];
      shift_d = shift_q << 1;
      cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CntW'(1));
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment display controller.
// Converts a loaded value to decimal (sequential double-dabble) or hex digits,
// commits them to digit registers and continuously scans the digits.
// Ports:
//   clk_in    sole clock
//   rst       asynchronous active-low reset
//   num       value to display, sampled on an accepted load
//   mode      0 = decimal, 1 = hexadecimal, sampled with num
//   load      single-cycle convert request, ignored while busy
//   busy      conversion or commit in progress
//   overflow  committed value does not fit NUM_DIGITS digits
//   anode     one-hot active-low digit enable
//   seg       active-low segments, seg[0]=a .. seg[6]=g
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DATA_W      = 13,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     num,
  input  logic                  mode,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg
);

  localparam int unsigned BcdW  = 4 * NUM_DIGITS;
  localparam int unsigned WideW = DATA_W + BcdW;
  localparam int unsigned RefW  = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_e           state_q, state_d;
  logic [DATA_W-1:0]     num_q, num_d;
  logic                  mode_q, mode_d;
  logic [BcdW-1:0]       dig_q, dig_d;
  logic                  ovf_q, ovf_d;
  logic [RefW-1:0]       ref_cnt_q, ref_cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;

  logic            conv_start;
  logic            conv_done;
  logic [BcdW-1:0] conv_bcd;
  logic            conv_ovf;
  logic [WideW-1:0] num_wide;
  logic            upper_zero;
  logic [6:0]      glyph [NUM_DIGITS];

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .DATA_W     (DATA_W)
  ) u_bin2bcd (
    .clk_i   (clk_in),
    .rst_ni  (rst),
    .start_i (conv_start),
    .bin_i   (num),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .ovf_o   (conv_ovf)
  );

  // Zero-extend so the hex overflow test is a plain OR of the bits above the digits.
  assign num_wide = WideW'(num_q);

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    mode_d     = mode_q;
    dig_d      = dig_q;
    ovf_d      = ovf_q;
    conv_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          num_d  = num;
          mode_d = mode;
          if (mode) begin
            state_d = StCommit;
          end else begin
            state_d    = StConv;
            conv_start = 1'b1;
          end
        end
      end
      StConv: begin
        if (conv_done) state_d = StCommit;
      end
      StCommit: begin
        state_d = StIdle;
        if (mode_q) begin
          dig_d = num_wide[BcdW-1:0];
          ovf_d = |num_wide[WideW-1:BcdW];
        end else begin
          dig_d = conv_bcd;
          ovf_d = conv_ovf;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Refresh divider and digit index, free-running regardless of the FSM.
  always_comb begin
    ref_cnt_d = ref_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (ref_cnt_q == RefW'(REFRESH_DIV - 1)) begin
      ref_cnt_d = '0;
      idx_d     = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Per-digit glyph; walking down from the top digit tracks whether every digit
  // at or above the current one is zero (leading-zero blanking).
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) glyph[i] = SegBlank;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (dig_q[4*i +: 4] == 4'd0);
      if (ovf_q) begin
        glyph[i] = SegDash;
      end else if ((BLANK_LZ != 0) && (i != 0) && upper_zero) begin
        glyph[i] = SegBlank;
      end else begin
        glyph[i] = hex_glyph(dig_q[4*i +: 4]);
      end
    end
  end

  always_comb begin
    anode_d = ~(NUM_DIGITS'(1) << idx_d);
    seg_d   = glyph[idx_d];
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      num_q     <= '0;
      mode_q    <= 1'b0;
      dig_q     <= '0;
      ovf_q     <= 1'b0;
      ref_cnt_q <= '0;
      idx_q     <= '0;
      anode_q   <= '1;
      seg_q     <= SegBlank;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      mode_q    <= mode_d;
      dig_q     <= dig_d;
      ovf_q     <= ovf_d;
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign overflow = ovf_q;
  assign anode    = anode_q;
  assign seg      = seg_q;

endmodule
